// File: rtl/instr_mem_loader_pkg.sv
// Shared instruction-memory parameters and the loader state encoding.
// Used by the loader, the word assembler and (elsewhere) the PC, fetch
// and instruction memory, so the widths stay consistent across the core.
package instr_mem_loader_pkg;

  localparam int unsigned INSTR_WIDTH    = 72;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned BYTES_PER_WORD = 9;
  localparam int unsigned ADDR_WIDTH     = 8;
  localparam int unsigned DEPTH          = 256;

  // Word counter needs one extra bit so that DEPTH itself is representable.
  localparam int unsigned CNT_WIDTH      = ADDR_WIDTH + 1;
  localparam int unsigned IDX_WIDTH      = $clog2(BYTES_PER_WORD);
  // Bytes that are still needed once the newest byte is appended.
  localparam int unsigned HIST_WIDTH     = INSTR_WIDTH - BYTE_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  // Requested word counts beyond the memory depth are clamped to DEPTH.
  function automatic logic [CNT_WIDTH-1:0] clamp_count(input logic [CNT_WIDTH-1:0] wc);
    if (wc > CNT_WIDTH'(DEPTH)) begin
      return CNT_WIDTH'(DEPTH);
    end
    return wc;
  endfunction

endpackage

// File: rtl/instr_mem_loader_assembler.sv
// instr_word_assembler: shifts handshaken bytes into a 72-bit instruction
// word (first byte ends up in the MSBs), tracks the byte index within the
// word and keeps a running XOR checksum over every assembled byte.
//
// Ports:
//   clk               system clock
//   reset             synchronous active-high reset
//   i_clear           restart assembly for a new load (index, history, checksum)
//   i_shift           a stream byte was handshaken and belongs to a word
//   i_byte            stream byte
//   o_word_next_c     word including i_byte (valid on the completing shift)
//   o_checksum        running XOR of all bytes shifted since the last clear
//   o_word_complete_c this shift supplies the last byte of the word
module instr_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_shift,
  input  logic [BYTE_WIDTH-1:0]  i_byte,
  output logic [INSTR_WIDTH-1:0] o_word_next_c,
  output logic [BYTE_WIDTH-1:0]  o_checksum,
  output logic                   o_word_complete_c
);

  // Only the newest 8 bytes need storing: the oldest byte of a full word is
  // taken straight from this history on the completing shift.
  logic [HIST_WIDTH-1:0]  r_hist;
  logic [BYTE_WIDTH-1:0]  r_checksum;
  logic [IDX_WIDTH-1:0]   r_byte_idx;
  logic [INSTR_WIDTH-1:0] w_word_next;
  logic                   w_last_byte;

  assign w_word_next = {r_hist, i_byte};
  assign w_last_byte = (r_byte_idx == IDX_WIDTH'(BYTES_PER_WORD - 1));

  // History shift, byte index and checksum update on each consumed byte.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_hist     <= '0;
      r_checksum <= '0;
      r_byte_idx <= '0;
    end else if (i_shift) begin
      r_hist     <= w_word_next[HIST_WIDTH-1:0];
      r_checksum <= r_checksum ^ i_byte;
      r_byte_idx <= w_last_byte ? '0 : r_byte_idx + IDX_WIDTH'(1);
    end
  end

  assign o_word_next_c     = w_word_next;
  assign o_checksum        = r_checksum;
  assign o_word_complete_c = i_shift && w_last_byte;

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: fills instruction memory from a byte stream. Every 9
// handshaken bytes form one 72-bit word written to ascending addresses from
// 0; a trailing XOR checksum byte is verified after the last word. The CPU
// is held (cpu_hold) while the load runs.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           one-cycle load request (ignored while busy)
//   word_count      words to load, sampled on an accepted start
//   byte_in         stream byte
//   byte_valid      stream byte valid
//   byte_ready      loader accepts a byte this cycle
//   mem_we          instruction memory write strobe (one cycle per word)
//   mem_addr        write address
//   mem_wdata       write data
//   busy            load in progress
//   cpu_hold        processor hold, identical to busy
//   done            one-cycle pulse at the end of a load
//   error           checksum mismatch, sticky until the next accepted start
module instr_mem_loader
  import instr_mem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   word_count,
  input  logic [BYTE_WIDTH-1:0]  byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  loader_state_t          r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_byte_ready;
  logic                   r_mem_we;
  logic [INSTR_WIDTH-1:0] r_mem_wdata;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic                   w_hs;
  logic                   w_start_ok;
  logic                   w_shift;
  logic                   w_last_word;
  logic                   w_word_complete;
  logic [INSTR_WIDTH-1:0] w_word_next;
  logic [BYTE_WIDTH-1:0]  w_checksum;

  assign w_hs        = byte_valid && r_byte_ready;
  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_shift     = (r_state == RECV) && w_hs;
  assign w_last_word = (CNT_WIDTH'(r_addr) == r_count - CNT_WIDTH'(1));

  instr_word_assembler u_asm (
    .clk               (clk),
    .reset             (reset),
    .i_clear           (w_start_ok),
    .i_shift           (w_shift),
    .i_byte            (byte_in),
    .o_word_next_c     (w_word_next),
    .o_checksum        (w_checksum),
    .o_word_complete_c (w_word_complete)
  );

  // Load sequencer; all outputs are registered and set on state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_addr       <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_count <= clamp_count(word_count);
            if (word_count == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_byte_ready <= 1'b1;
              r_state      <= RECV;
            end
          end
        end
        RECV: begin
          // The assembler's next-word view already includes this byte.
          if (w_word_complete) begin
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b1;
            r_mem_wdata  <= w_word_next;
            r_state      <= WRITE;
          end
        end
        WRITE: begin
          r_byte_ready <= 1'b1;
          if (w_last_word) begin
            r_state <= CHECK;
          end else begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_state <= RECV;
          end
        end
        CHECK: begin
          // The checksum byte itself is compared, never accumulated.
          if (w_hs) begin
            r_error      <= (byte_in != w_checksum);
            r_byte_ready <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign cpu_hold   = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected memory writes are queued
// as words are driven and matched against mem_we cycles.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [71:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  typedef struct {
    logic [7:0]  addr;
    logic [71:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  int  n_done   = 0;
  logic [7:0] last_addr = '0;

  instr_mem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: every mem_we cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      n_writes++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {64'd0, mem_addr}, 72'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", {64'd0, mem_addr}, {64'd0, e.addr});
        check_eq("wr_data", mem_wdata, e.data);
      end
    end
    if (done) n_done++;
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("hs_timeout", 72'd0, 72'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Drives one word derived from seed, queuing the expected write first.
  task automatic send_word(input logic [7:0] addr, input logic [7:0] seed,
                           input bit gaps, inout logic [7:0] csum);
    logic [71:0] w = '0;
    logic [7:0]  b;
    for (int i = 0; i < 9; i++) begin
      b    = seed + 8'(i);
      w    = {w[63:0], b};
      csum = csum ^ b;
    end
    exp_q.push_back('{addr, w});
    for (int i = 0; i < 9; i++) begin
      send_byte(seed + 8'(i));
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [8:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] csum;
    int w0;
    int d0;

    // Reset held with byte_valid asserted.
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_byte_ready", {71'd0, byte_ready}, 72'd0);
    check_eq("rst_mem_we",     {71'd0, mem_we},     72'd0);
    check_eq("rst_busy",       {71'd0, busy},       72'd0);
    check_eq("rst_done",       {71'd0, done},       72'd0);
    check_eq("rst_error",      {71'd0, error},      72'd0);
    check_eq("rst_mem_addr",   {64'd0, mem_addr},   72'd0);
    byte_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);

    // Single word, bytes 01..09, correct checksum 01.
    pulse_start(9'd1);
    check_eq("t1_busy",     {71'd0, busy},     72'd1);
    check_eq("t1_cpu_hold", {71'd0, cpu_hold}, 72'd1);
    exp_q.push_back('{8'h00, 72'h010203040506070809});
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    check_eq("t1_we_latency", {71'd0, mem_we},     72'd1);
    check_eq("t1_ready_low",  {71'd0, byte_ready}, 72'd0);
    send_byte(8'h01);
    check_eq("t1_done",  {71'd0, done},  72'd1);
    check_eq("t1_busy_in_done", {71'd0, busy}, 72'd1);
    check_eq("t1_error", {71'd0, error}, 72'd0);
    @(negedge clk);
    check_eq("t1_busy_after", {71'd0, busy},     72'd0);
    check_eq("t1_hold_after", {71'd0, cpu_hold}, 72'd0);
    check_eq("t1_done_pulse", {71'd0, done},     72'd0);
    check_eq("t1_q_empty", 72'(exp_q.size()), 72'd0);

    // Two words with valid toggling; both words identical so XOR is 00.
    csum = '0;
    pulse_start(9'd2);
    send_word(8'h00, 8'hA0, 1'b1, csum);
    send_word(8'h01, 8'hA0, 1'b1, csum);
    check_eq("t2_model_csum", {64'd0, csum}, 72'd0);
    send_byte(8'hFF);
    check_eq("t2_done",  {71'd0, done},  72'd1);
    check_eq("t2_error", {71'd0, error}, 72'd1);
    repeat (5) @(negedge clk);
    check_eq("t2_error_sticky", {71'd0, error}, 72'd1);
    check_eq("t2_q_empty", 72'(exp_q.size()), 72'd0);

    // Zero-length load: done next cycle, no write, error cleared by start.
    w0 = n_writes;
    pulse_start(9'd0);
    check_eq("t3_done",  {71'd0, done},  72'd1);
    check_eq("t3_busy",  {71'd0, busy},  72'd1);
    check_eq("t3_error_cleared", {71'd0, error}, 72'd0);
    @(negedge clk);
    check_eq("t3_done_pulse", {71'd0, done}, 72'd0);
    check_eq("t3_busy_drop",  {71'd0, busy}, 72'd0);
    check_eq("t3_no_write", 72'(n_writes - w0), 72'd0);

    // Start during a load is ignored; original count of 2 stands.
    w0   = n_writes;
    csum = '0;
    pulse_start(9'd2);
    send_word(8'h00, 8'h30, 1'b0, csum);
    start = 1'b1; word_count = 9'd5;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_busy_mid", {71'd0, busy}, 72'd1);
    send_word(8'h01, 8'h40, 1'b0, csum);
    send_byte(csum);
    check_eq("t4_done",  {71'd0, done},  72'd1);
    check_eq("t4_error", {71'd0, error}, 72'd0);
    check_eq("t4_writes", 72'(n_writes - w0), 72'd2);

    // Reset partway through the second word of a 3-word load.
    @(negedge clk);
    csum = '0;
    pulse_start(9'd3);
    send_word(8'h00, 8'h55, 1'b0, csum);
    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i));
    w0 = n_writes;
    d0 = n_done;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("t5_busy",  {71'd0, busy},       72'd0);
    check_eq("t5_ready", {71'd0, byte_ready}, 72'd0);
    check_eq("t5_addr",  {64'd0, mem_addr},   72'd0);
    repeat (15) @(negedge clk);
    check_eq("t5_no_write", 72'(n_writes - w0), 72'd0);
    check_eq("t5_no_done",  72'(n_done - d0),   72'd0);
    csum = '0;
    pulse_start(9'd1);
    send_word(8'h00, 8'h70, 1'b0, csum);
    send_byte(csum);
    check_eq("t5_fresh_done",  {71'd0, done},  72'd1);
    check_eq("t5_fresh_error", {71'd0, error}, 72'd0);

    // Clamp: 300 requested, 256 written, last address FF.
    @(negedge clk);
    w0   = n_writes;
    csum = '0;
    pulse_start(9'd300);
    for (int k = 0; k < 256; k++) send_word(8'(k), 8'(k * 3 + 1), 1'b0, csum);
    check_eq("t6_ready_check", {71'd0, byte_ready}, 72'd0);
    send_byte(csum);
    check_eq("t6_writes", 72'(n_writes - w0), 72'd256);
    check_eq("t6_last_addr", {64'd0, last_addr}, 72'hFF);
    check_eq("t6_done",  {71'd0, done},  72'd1);
    check_eq("t6_error", {71'd0, error}, 72'd0);
    check_eq("t6_q_empty", 72'(exp_q.size()), 72'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
